decode_rf_stage: RTL

//  Y86-64 decode stage for the pipelined core. It holds the register file and

---
 rtl/y86_pkg.sv | 82 ++++++++
 rtl/decode_rf_stage_if.sv | 58 +++++
 rtl/y86_regfile.sv | 58 +++++
 rtl/decode_rf_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, register IDs, decode helpers.
// Used by the decode stage and its register file.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] RNONE       = 4'hF;
  localparam logic [3:0] RSP_DEFAULT = 4'h4;

  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } de_ids_t;

  localparam de_ids_t DE_IDS_NOP = '{
    icode: ICODE_NOP, ifun: 4'h0,
    src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE
  };

  function automatic logic [3:0] sel_src_a(input logic [3:0] icode, input logic [3:0] ra,
                                           input logic [3:0] rsp);
    logic [3:0] id;
    id = RNONE;
    case (icode)
      ICODE_RRMOVQ, ICODE_RMMOVQ, ICODE_OPQ, ICODE_PUSHQ: id = ra;
      ICODE_RET, ICODE_POPQ:                              id = rsp;
      default:                                            id = RNONE;
    endcase
    return id;
  endfunction

  function automatic logic [3:0] sel_src_b(input logic [3:0] icode, input logic [3:0] rb,
                                           input logic [3:0] rsp);
    logic [3:0] id;
    id = RNONE;
    case (icode)
      ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_OPQ:                 id = rb;
      ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:         id = rsp;
      default:                                                id = RNONE;
    endcase
    return id;
  endfunction

  // Conditional moves keep rB here; execute squashes the write on a false condition.
  function automatic logic [3:0] sel_dst_e(input logic [3:0] icode, input logic [3:0] rb,
                                           input logic [3:0] rsp);
    logic [3:0] id;
    id = RNONE;
    case (icode)
      ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_OPQ:                 id = rb;
      ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:         id = rsp;
      default:                                                id = RNONE;
    endcase
    return id;
  endfunction

  function automatic logic [3:0] sel_dst_m(input logic [3:0] icode, input logic [3:0] ra);
    logic [3:0] id;
    id = RNONE;
    case (icode)
      ICODE_MRMOVQ, ICODE_POPQ: id = ra;
      default:                  id = RNONE;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/decode_rf_stage_if.sv
// Fetch->decode inputs, write-back ports, hazard control and D->E outputs.
// Forwarding ports exist only when DECODE_FWD_EN is defined.
interface decode_rf_stage_if #(
  parameter int XLEN = 64
);
  logic            d_valid;
  logic [3:0]      d_icode;
  logic [3:0]      d_ifun;
  logic [3:0]      d_ra;
  logic [3:0]      d_rb;
  logic [XLEN-1:0] d_valC;
  logic [XLEN-1:0] d_valP;
  logic            e_stall;
  logic            e_bubble;
  logic [3:0]      w_dstE;
  logic [XLEN-1:0] w_valE;
  logic [3:0]      w_dstM;
  logic [XLEN-1:0] w_valM;
`ifdef DECODE_FWD_EN
  logic [3:0]      fwd_e_dstE;
  logic [XLEN-1:0] fwd_e_valE;
  logic [3:0]      fwd_m_dstM;
  logic [XLEN-1:0] fwd_m_valM;
  logic [3:0]      fwd_m_dstE;
  logic [XLEN-1:0] fwd_m_valE;
`endif
  logic            e_valid;
  logic [3:0]      e_icode;
  logic [3:0]      e_ifun;
  logic [XLEN-1:0] e_valA;
  logic [XLEN-1:0] e_valB;
  logic [XLEN-1:0] e_valC;
  logic [3:0]      e_srcA;
  logic [3:0]      e_srcB;
  logic [3:0]      e_dstE;
  logic [3:0]      e_dstM;

  modport master (
    output d_valid, d_icode, d_ifun, d_ra, d_rb, d_valC, d_valP,
    output e_stall, e_bubble, w_dstE, w_valE, w_dstM, w_valM,
`ifdef DECODE_FWD_EN
    output fwd_e_dstE, fwd_e_valE, fwd_m_dstM, fwd_m_valM, fwd_m_dstE, fwd_m_valE,
`endif
    input  e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC,
    input  e_srcA, e_srcB, e_dstE, e_dstM
  );

  modport slave (
    input  d_valid, d_icode, d_ifun, d_ra, d_rb, d_valC, d_valP,
    input  e_stall, e_bubble, w_dstE, w_valE, w_dstM, w_valM,
`ifdef DECODE_FWD_EN
    input  fwd_e_dstE, fwd_e_valE, fwd_m_dstM, fwd_m_valM, fwd_m_dstE, fwd_m_valE,
`endif
    output e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC,
    output e_srcA, e_srcB, e_dstE, e_dstM
  );

endinterface

// File: rtl/y86_regfile.sv
// NREG x XLEN register file, 2 combinational reads / 2 clocked writes.
// Latency: reads 0 cycles with write-through bypass; writes land on the next rising edge.
// Backpressure: none; writes are always accepted, M beats E on the same ID.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      ra_id,
  input  logic [3:0]      rb_id,
  output logic [XLEN-1:0] ra_val,
  output logic [XLEN-1:0] rb_val,
  input  logic [3:0]      we_id,
  input  logic [XLEN-1:0] we_val,
  input  logic [3:0]      wm_id,
  input  logic [XLEN-1:0] wm_val
);

  logic [XLEN-1:0] rf [NREG];
  logic            ra_ok, rb_ok;

  assign ra_ok = (ra_id != RNONE) && (int'(ra_id) < NREG);
  assign rb_ok = (rb_id != RNONE) && (int'(rb_id) < NREG);

  // A valid read ID can only match a valid write ID, so the bypass needs no extra qualification.
  always_comb begin
    ra_val = '0;
    if (ra_ok) begin
      if (wm_id == ra_id)      ra_val = wm_val;
      else if (we_id == ra_id) ra_val = we_val;
      else                     ra_val = rf[ra_id];
    end
  end

  always_comb begin
    rb_val = '0;
    if (rb_ok) begin
      if (wm_id == rb_id)      rb_val = wm_val;
      else if (we_id == rb_id) rb_val = we_val;
      else                     rb_val = rf[rb_id];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_id != RNONE && we_id == 4'(i)) rf[i] <= we_val;
        if (wm_id != RNONE && wm_id == 4'(i)) rf[i] <= wm_val;
      end
    end
  end

endmodule

// File: rtl/decode_rf_stage.sv
// Y86-64 decode: source/destination select, operand read, D->E pipeline register.
// Latency 1 cycle; optional forwarding paths enabled by DECODE_FWD_EN.
// Backpressure: e_stall holds the D->E register (wins over e_bubble); RF writes never stall.
module decode_rf_stage
  import y86_pkg::*;
#(
  parameter int         XLEN   = 64,
  parameter int         NREG   = 15,
  parameter logic [3:0] RSP_ID = RSP_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  decode_rf_stage_if.slave bus
);

  de_ids_t         dec_ids;
  de_ids_t         de_ids_q;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [XLEN-1:0] opnd_a, opnd_b;
  logic [XLEN-1:0] val_a;
  logic [XLEN-1:0] val_a_q, val_b_q, val_c_q;
  logic            vld_q;

  always_comb begin
    dec_ids       = DE_IDS_NOP;
    dec_ids.icode = bus.d_icode;
    dec_ids.ifun  = bus.d_ifun;
    dec_ids.src_a = sel_src_a(bus.d_icode, bus.d_ra, RSP_ID);
    dec_ids.src_b = sel_src_b(bus.d_icode, bus.d_rb, RSP_ID);
    dec_ids.dst_e = sel_dst_e(bus.d_icode, bus.d_rb, RSP_ID);
    dec_ids.dst_m = sel_dst_m(bus.d_icode, bus.d_ra);
  end

  y86_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra_id  (dec_ids.src_a),
    .rb_id  (dec_ids.src_b),
    .ra_val (rf_a),
    .rb_val (rf_b),
    .we_id  (bus.w_dstE),
    .we_val (bus.w_valE),
    .wm_id  (bus.w_dstM),
    .wm_val (bus.w_valM)
  );

`ifdef DECODE_FWD_EN
  // Younger producers win: execute, then memory load data, then memory ALU result.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [3:0] id,     input logic [XLEN-1:0] base,
    input logic [3:0] e_id,   input logic [XLEN-1:0] e_val,
    input logic [3:0] mm_id,  input logic [XLEN-1:0] mm_val,
    input logic [3:0] me_id,  input logic [XLEN-1:0] me_val
  );
    logic [XLEN-1:0] v;
    v = base;
    if (id != RNONE) begin
      if (e_id == id)       v = e_val;
      else if (mm_id == id) v = mm_val;
      else if (me_id == id) v = me_val;
    end
    return v;
  endfunction

  always_comb begin
    opnd_a = fwd_pick(dec_ids.src_a, rf_a, bus.fwd_e_dstE, bus.fwd_e_valE,
                      bus.fwd_m_dstM, bus.fwd_m_valM, bus.fwd_m_dstE, bus.fwd_m_valE);
    opnd_b = fwd_pick(dec_ids.src_b, rf_b, bus.fwd_e_dstE, bus.fwd_e_valE,
                      bus.fwd_m_dstM, bus.fwd_m_valM, bus.fwd_m_dstE, bus.fwd_m_valE);
  end
`else
  assign opnd_a = rf_a;
  assign opnd_b = rf_b;
`endif

  // Jumps and calls carry the fall-through PC to execute in valA.
  assign val_a = (bus.d_icode == ICODE_JXX || bus.d_icode == ICODE_CALL) ? bus.d_valP : opnd_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      de_ids_q <= DE_IDS_NOP;
      val_a_q  <= '0;
      val_b_q  <= '0;
      val_c_q  <= '0;
    end else if (!bus.e_stall) begin
      if (bus.e_bubble || !bus.d_valid) begin
        vld_q    <= 1'b0;
        de_ids_q <= DE_IDS_NOP;
        val_a_q  <= '0;
        val_b_q  <= '0;
        val_c_q  <= '0;
      end else begin
        vld_q    <= 1'b1;
        de_ids_q <= dec_ids;
        val_a_q  <= val_a;
        val_b_q  <= opnd_b;
        val_c_q  <= bus.d_valC;
      end
    end
  end

  assign bus.e_valid = vld_q;
  assign bus.e_icode = de_ids_q.icode;
  assign bus.e_ifun  = de_ids_q.ifun;
  assign bus.e_srcA  = de_ids_q.src_a;
  assign bus.e_srcB  = de_ids_q.src_b;
  assign bus.e_dstE  = de_ids_q.dst_e;
  assign bus.e_dstM  = de_ids_q.dst_m;
  assign bus.e_valA  = val_a_q;
  assign bus.e_valB  = val_b_q;
  assign bus.e_valC  = val_c_q;

endmodule
